// File: rtl/i2c_write_engine.sv
// i2c_write_engine
// Bit-level I2C master that sends one 3-byte write frame
// {slave_addr, sub_addr, data} MSB first, with a level GO / END handshake
// and a sticky NACK flag. Runs on iCLK with a clock-enable divider; every
// divider tick is one quarter of an SCLK period.
//
// Optional feature macro: I2C_WRITE_ABORT_ON_NACK_EN
//   defined   -> a NACK in any ACK slot ends the frame with an immediate STOP
//   undefined -> all three bytes are always sent; oACK still records the NACK
//
// Handshake: iGO is a level request sampled on divider ticks while idle.
// The frame is accepted (oBUSY rises) on the first tick with iGO=1. oEND
// rises when the frame is complete and stays high until iGO is seen low on
// any clock, at which point oEND and oBUSY fall together.
module i2c_write_engine #(
    parameter int CLK_Freq = 50000000,
    parameter int I2C_Freq = 20000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [23:0] iDATA,
    input  logic        iGO,
    output logic        oEND,
    output logic        oACK,
    output logic        oBUSY,
    output logic        oI2C_SCLK,
    inout  wire         ioI2C_SDAT
);

    localparam int DIV_RAW = CLK_Freq / (4 * I2C_Freq);
    localparam int DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [15:0] divCnt;
    logic        tick;
    logic [1:0]  quarter;
    logic [2:0]  bitCnt;
    logic [1:0]  byteCnt;
    logic [23:0] shiftReg;
    logic        ackReg;
    logic        sclOut;
    logic        sdaLow;
    logic        abortOnNack;

`ifdef I2C_WRITE_ABORT_ON_NACK_EN
    assign abortOnNack = 1'b1;
`else
    assign abortOnNack = 1'b0;
`endif

    // Free-running divider; tick marks the last cycle of each quarter period.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            divCnt <= 16'd0;
        end else if (divCnt == DIV_LAST) begin
            divCnt <= 16'd0;
        end else begin
            divCnt <= divCnt + 16'd1;
        end
    end

    assign tick = (divCnt == DIV_LAST);

    // State register.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: bus states advance on the tick that ends quarter 3;
    // leaving DONE is clock-accurate so oEND can be a single-cycle pulse.
    always_comb begin
        nextState = state;
        unique case (state)
            ST_IDLE: begin
                if (tick && iGO) nextState = ST_START;
            end
            ST_START: begin
                if (tick && quarter == 2'd3) nextState = ST_BIT;
            end
            ST_BIT: begin
                if (tick && quarter == 2'd3 && bitCnt == 3'd0) nextState = ST_ACK;
            end
            ST_ACK: begin
                if (tick && quarter == 2'd3) begin
                    // ackReg already holds this slot's sample (taken at q2);
                    // with abort enabled it can only be set by this byte.
                    if (abortOnNack && ackReg) begin
                        nextState = ST_STOP;
                    end else if (byteCnt < 2'd2) begin
                        nextState = ST_BIT;
                    end else begin
                        nextState = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick && quarter == 2'd3) nextState = ST_DONE;
            end
            ST_DONE: begin
                if (!iGO) nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // Datapath: frame latch, quarter/bit/byte counters and the sticky NACK flag.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            quarter  <= 2'd0;
            bitCnt   <= 3'd0;
            byteCnt  <= 2'd0;
            shiftReg <= 24'd0;
            ackReg   <= 1'b0;
        end else if (tick) begin
            unique case (state)
                ST_IDLE: begin
                    if (iGO) begin
                        shiftReg <= iDATA;
                        ackReg   <= 1'b0;
                        quarter  <= 2'd0;
                        bitCnt   <= 3'd7;
                        byteCnt  <= 2'd0;
                    end
                end
                ST_START, ST_STOP: begin
                    quarter <= quarter + 2'd1;
                end
                ST_BIT: begin
                    quarter <= quarter + 2'd1;
                    if (quarter == 2'd3) begin
                        shiftReg <= {shiftReg[22:0], 1'b0};
                        if (bitCnt != 3'd0) bitCnt <= bitCnt - 3'd1;
                    end
                end
                ST_ACK: begin
                    quarter <= quarter + 2'd1;
                    if (quarter == 2'd2 && ioI2C_SDAT == 1'b1) ackReg <= 1'b1;
                    if (quarter == 2'd3) begin
                        bitCnt  <= 3'd7;
                        byteCnt <= byteCnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode: SCL/SDA waveform per state and quarter, plus handshake flags.
    always_comb begin
        sclOut = 1'b1;
        sdaLow = 1'b0;
        unique case (state)
            ST_START: begin
                sclOut = (quarter == 2'd0) || (quarter == 2'd1);
                sdaLow = (quarter != 2'd0);
            end
            ST_BIT: begin
                sclOut = (quarter == 2'd1) || (quarter == 2'd2);
                sdaLow = !shiftReg[23];
            end
            ST_ACK: begin
                sclOut = (quarter == 2'd1) || (quarter == 2'd2);
                sdaLow = 1'b0;
            end
            ST_STOP: begin
                sclOut = (quarter != 2'd0);
                sdaLow = (quarter == 2'd0) || (quarter == 2'd1);
            end
            default: begin
                sclOut = 1'b1;
                sdaLow = 1'b0;
            end
        endcase
    end

    assign oI2C_SCLK  = sclOut;
    assign ioI2C_SDAT = sdaLow ? 1'b0 : 1'bz;
    assign oEND       = (state == ST_DONE);
    assign oBUSY      = (state != ST_IDLE);
    assign oACK       = ackReg;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: I2C slave model with pull-up, byte scoreboard,
// table of frames plus hand-written handshake and mid-frame reset sequences.
module tb_i2c_write_engine;

  logic        iCLK;
  logic        iRST_N;
  logic [23:0] iDATA;
  logic        iGO;
  logic        oEND;
  logic        oACK;
  logic        oBUSY;
  logic        oI2C_SCLK;
  wire         sda;

  logic        slave_low;
  logic [2:0]  nack_mask;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_write_engine #(
    .CLK_Freq(800000),
    .I2C_Freq(50000)
  ) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .iDATA(iDATA),
    .iGO(iGO),
    .oEND(oEND),
    .oACK(oACK),
    .oBUSY(oBUSY),
    .oI2C_SCLK(oI2C_SCLK),
    .ioI2C_SDAT(sda)
  );

  // clock / reset
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got timeout required completion");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // slave model: START/STOP detection, bit capture on SCL rise, ACK drive
  int start_cnt = 0;
  int stop_cnt = 0;
  int bit_idx = 0;
  int byte_idx = 0;
  bit ack_phase = 0;
  logic [7:0] shift_in = 8'h00;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;

  initial slave_low = 1'b0;

  always @(negedge iCLK) begin
    logic scl_s;
    logic sda_s;
    scl_s = (oI2C_SCLK === 1'b1);
    sda_s = (sda === 1'b0) ? 1'b0 : 1'b1;
    if (prev_scl && scl_s && prev_sda && !sda_s) begin
      start_cnt++;
      bit_idx = 0;
      byte_idx = 0;
      ack_phase = 0;
      slave_low = 1'b0;
    end else if (prev_scl && scl_s && !prev_sda && sda_s) begin
      stop_cnt++;
    end else if (!prev_scl && scl_s) begin
      if (bit_idx < 8) begin
        shift_in = {shift_in[6:0], sda_s};
        bit_idx++;
        if (bit_idx == 8) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL byte_extra: got %0h required no byte", shift_in);
          end else begin
            check("byte", {24'd0, shift_in}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end else if (prev_scl && !scl_s) begin
      if (ack_phase) begin
        slave_low = 1'b0;
        ack_phase = 0;
        bit_idx = 0;
        byte_idx++;
      end else if (bit_idx == 8) begin
        slave_low = (byte_idx < 3) ? !nack_mask[byte_idx] : 1'b1;
        ack_phase = 1;
      end
    end
    prev_scl = scl_s;
    prev_sda = (sda === 1'b0) ? 1'b0 : 1'b1;
  end

  typedef struct {
    logic [23:0] data;
    logic [2:0]  mask;
    bit          hold_go;
    logic        exp_ack;
    int          n_bytes;
    int          quarters;
  } vec_t;

  vec_t vecs[5];

  // driver: one frame, with acceptance, END timing, ACK flag and handshake checks
  task automatic run_frame(input vec_t v);
    int cnt;
    for (int b = 0; b < v.n_bytes; b++) exp_q.push_back(v.data[23 - 8 * b -: 8]);
    nack_mask = v.mask;
    start_cnt = 0;
    stop_cnt = 0;
    iDATA = v.data;
    iGO = 1'b1;
    cnt = 0;
    while (!oBUSY && cnt < 20) begin
      @(negedge iCLK);
      cnt++;
    end
    check("accept_latency_ok", {31'd0, (oBUSY === 1'b1) && (cnt <= 4)}, 32'd1);
    iDATA = 24'($urandom);
    if (!v.hold_go) iGO = 1'b0;
    cnt = 0;
    while (!oEND && cnt < 2000) begin
      @(negedge iCLK);
      cnt++;
    end
    check("end_timing_ok", {31'd0, (oEND === 1'b1) && (cnt >= v.quarters * 4 - 4)
                            && (cnt <= v.quarters * 4 + 4)}, 32'd1);
    check("busy_in_done", {31'd0, oBUSY}, 32'd1);
    check("ack_flag", {31'd0, oACK}, {31'd0, v.exp_ack});
    check("start_count", start_cnt, 32'd1);
    check("stop_count", stop_cnt, 32'd1);
    check("bytes_left", exp_q.size(), 32'd0);
    if (v.hold_go) begin
      cnt = 0;
      repeat (50) begin
        @(negedge iCLK);
        if (oEND === 1'b1) cnt++;
      end
      check("end_held", cnt, 32'd50);
      iGO = 1'b0;
    end
    @(negedge iCLK);
    check("end_clear", {31'd0, oEND}, 32'd0);
    check("busy_clear", {31'd0, oBUSY}, 32'd0);
    check("ack_hold", {31'd0, oACK}, {31'd0, v.exp_ack});
    exp_q.delete();
  endtask

  initial begin
    vec_t v;
    int cnt;
`ifdef I2C_WRITE_ABORT_ON_NACK_EN
    vecs[0] = '{24'h340C00, 3'b000, 1'b1, 1'b0, 3, 116};
    vecs[1] = '{24'h401500, 3'b010, 1'b0, 1'b1, 2, 80};
    vecs[2] = '{24'hA55AFF, 3'b000, 1'b1, 1'b0, 3, 116};
    vecs[3] = '{24'h123456, 3'b100, 1'b0, 1'b1, 3, 116};
    vecs[4] = '{24'hFF0081, 3'b001, 1'b0, 1'b1, 1, 44};
`else
    vecs[0] = '{24'h340C00, 3'b000, 1'b1, 1'b0, 3, 116};
    vecs[1] = '{24'h401500, 3'b010, 1'b0, 1'b1, 3, 116};
    vecs[2] = '{24'hA55AFF, 3'b000, 1'b1, 1'b0, 3, 116};
    vecs[3] = '{24'h123456, 3'b100, 1'b0, 1'b1, 3, 116};
    vecs[4] = '{24'hFF0081, 3'b001, 1'b0, 1'b1, 3, 116};
`endif
    nack_mask = 3'b000;
    iRST_N = 1'b0;
    iGO = 1'b0;
    iDATA = 24'd0;
    repeat (10) @(negedge iCLK);
    check("rst_sclk", {31'd0, oI2C_SCLK}, 32'd1);
    check("rst_sdat", {31'd0, sda}, 32'd1);
    check("rst_end", {31'd0, oEND}, 32'd0);
    check("rst_ack", {31'd0, oACK}, 32'd0);
    check("rst_busy", {31'd0, oBUSY}, 32'd0);
    iRST_N = 1'b1;
    repeat ($urandom_range(1, 7)) @(negedge iCLK);

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // mid-frame reset during byte 1, bit 3
    exp_q.push_back(8'h34);
    nack_mask = 3'b000;
    iDATA = 24'h340C00;
    iGO = 1'b1;
    cnt = 0;
    while (!oBUSY && cnt < 20) begin
      @(negedge iCLK);
      cnt++;
    end
    iGO = 1'b0;
    cnt = 0;
    while (!(byte_idx == 1 && bit_idx == 5) && cnt < 1000) begin
      @(negedge iCLK);
      cnt++;
    end
    check("reached_byte1_bit3", {31'd0, byte_idx == 1 && bit_idx == 5}, 32'd1);
    iRST_N = 1'b0;
    @(negedge iCLK);
    check("midrst_sclk", {31'd0, oI2C_SCLK}, 32'd1);
    check("midrst_sdat", {31'd0, sda}, 32'd1);
    check("midrst_busy", {31'd0, oBUSY}, 32'd0);
    check("midrst_end", {31'd0, oEND}, 32'd0);
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge iCLK);

    v = '{24'h340C00, 3'b000, 1'b0, 1'b0, 3, 116};
    run_frame(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
